// File: rtl/intra_filter_pkg.sv
// Shared defaults, widths and FSM state for the intra filter path.
// Imported by the tap accumulator and its round/clip stage.
package intra_filter_pkg;

  localparam int NUM_TAPS_DEF = 4;
  localparam int PROD_W_DEF   = 16;
  localparam int SHIFT_DEF    = 6;
  localparam int PIX_W_DEF    = 8;

  // One sign bit of headroom over the worst-case sum of num_taps products.
  function automatic int acc_width(input int prod_w, input int num_taps);
    return prod_w + $clog2(num_taps) + 1;
  endfunction

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    STALL = 1'b1
  } acc_state_e;

endpackage

// File: rtl/intra_round_clip.sv
// Rounds a filter sum by 2^SHIFT (floor after half-bias) and clips
// the result to the unsigned PIX_W sample range.
module intra_round_clip
  import intra_filter_pkg::*;
#(
  parameter int AW    = acc_width(PROD_W_DEF, NUM_TAPS_DEF),
  parameter int SHIFT = SHIFT_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic signed [AW-1:0] sum_i,
  output logic [PIX_W-1:0]     pix_o
);

  localparam int RND_I = 1 << (SHIFT - 1);
  localparam int MAX_I = (1 << PIX_W) - 1;
  localparam logic signed [AW-1:0] RND  = AW'(RND_I);
  localparam logic signed [AW-1:0] MAXV = AW'(MAX_I);

  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] shifted;

  // Bias, arithmetic shift, then saturate to [0, 2^PIX_W-1].
  always_comb begin
    biased  = sum_i + RND;
    shifted = biased >>> SHIFT;
    if (shifted < 0) begin
      pix_o = '0;
    end else if (shifted > MAXV) begin
      pix_o = '1;
    end else begin
      pix_o = shifted[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/intra_tap_accumulator.sv
// Accumulates NUM_TAPS signed products per predicted sample and
// emits one rounded, clipped pixel through a single output register.
module intra_tap_accumulator
  import intra_filter_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int PROD_W   = PROD_W_DEF,
  parameter int SHIFT    = SHIFT_DEF,
  parameter int PIX_W    = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [PROD_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PIX_W-1:0]         m_data,
  output logic                     err
);

  localparam int AW = acc_width(PROD_W, NUM_TAPS);
  localparam int CW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(NUM_TAPS - 1);

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        tap_q, tap_d;
  acc_state_e           state_q, state_d;
  logic                 m_valid_q, m_valid_d;
  logic [PIX_W-1:0]     m_data_q, m_data_d;
  logic                 err_q, err_d;

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] sum;
  logic [PIX_W-1:0]     pix;
  logic                 is_final;
  logic                 hold;
  logic                 fire;
  logic                 done;

  // Handshake and running sum; tap 0 loads instead of adding.
  // An early s_last also ends a sample, so it must not overwrite
  // an output that is still waiting to be taken.
  always_comb begin
    ext      = {{(AW - PROD_W){s_data[PROD_W-1]}}, s_data};
    is_final = (tap_q == LAST_TAP);
    hold     = m_valid_q && !m_ready;
    s_ready  = !(hold && (state_q == STALL || is_final
                          || (s_valid && s_last)));
    fire     = s_valid && s_ready;
    done     = fire && (is_final || s_last);
    sum      = (tap_q == '0) ? ext : acc_q + ext;
  end

  intra_round_clip #(
    .AW    (AW),
    .SHIFT (SHIFT),
    .PIX_W (PIX_W)
  ) u_round_clip (
    .sum_i (sum),
    .pix_o (pix)
  );

  // Next-state: accumulator, tap counter, output register, error, FSM.
  always_comb begin
    acc_d     = acc_q;
    tap_d     = tap_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    err_d     = err_q;
    state_d   = state_q;

    if (fire) begin
      acc_d = sum;
      tap_d = done ? '0 : tap_q + CW'(1);
      if (s_last != is_final) begin
        err_d = 1'b1;
      end
    end

    if (done) begin
      m_valid_d = 1'b1;
      m_data_d  = pix;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ACCUM: if (is_final && hold) state_d = STALL;
      STALL: if (m_ready)          state_d = ACCUM;
      default:                     state_d = ACCUM;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      tap_q     <= '0;
      state_q   <= ACCUM;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      tap_q     <= tap_d;
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_intra_tap_accumulator.sv
// Scoreboard bench for intra_tap_accumulator: expected pixels queued
// on final-tap acceptance, compared when the output handshakes.
module tb_intra_tap_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        err;

  intra_tap_accumulator dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];
  int taps[8];
  int tb_tap = 0;
  int n_push = 0;
  int n_out = 0;
  int stall_cnt = 0;
  int stall_bad = 0;
  bit bp_en = 1'b0;
  bit hold_q = 1'b0;
  logic [7:0] held_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_pix(input int s);
    int q;
    q = (s + 32) >>> 6;
    if (q < 0) return 0;
    if (q > 255) return 255;
    return q;
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic drive_tap(input int d, input bit last);
    int w;
    bit ok;
    w = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = 16'(d);
    s_last = last;
    while (!ok) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
      end else begin
        stall_cnt++;
        if (!last) stall_bad++;
      end
      @(posedge clk);
      #1;
      w++;
      if (!ok && w > 1000) begin
        $display("FAIL s_ready_timeout: got 0 expected 1");
        $fatal(1, "s_ready never asserted");
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send(input int n, input int lastpos, input int expv);
    int sum;
    bit l;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      l = (i == lastpos);
      drive_tap(taps[i], l);
      sum += taps[i];
      if (l || tb_tap == 3) begin
        sb.push_back(expv < 0 ? exp_pix(sum) : expv);
        n_push++;
        sum = 0;
        tb_tap = 0;
      end else begin
        tb_tap++;
      end
    end
  endtask

  task automatic set4(input int a, input int b, input int c,
                      input int d);
    taps[0] = a;
    taps[1] = b;
    taps[2] = c;
    taps[3] = d;
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) m_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held_d);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("sb_underflow", m_valid, 0);
        else chk("out_data", m_data, sb.pop_front());
        n_out++;
      end
      hold_q = m_valid && !m_ready;
      held_d = m_data;
    end
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // nominal sample, latency 1
    set4(-200, 5800, 1000, -200);
    chk("t29_pre_valid", m_valid, 0);
    send(4, 3, 100);
    chk("t29_valid", m_valid, 1);
    chk("t29_data", m_data, 100);
    chk("t29_err", err, 0);

    // negative result clips to 0, large result to 255
    set4(-1000, 0, 0, 0);
    send(4, 3, 0);
    set4(16320, 16320, 16320, 16320);
    send(4, 3, 255);
    repeat (2) @(posedge clk);
    #1;
    chk("t31_err", err, 0);

    // back-pressure: second final tap stalls, first output held
    m_ready = 1'b0;
    stall_cnt = 0;
    stall_bad = 0;
    fork
      begin
        set4(640, 640, 640, 640);
        send(4, 3, 40);
        set4(1280, 1280, 1280, 1280);
        send(4, 3, 80);
      end
      begin
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    chk("t32_stalled", stall_cnt > 0, 1);
    chk("t32_stall_pos", stall_bad, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t32_err", err, 0);

    // early s_last on tap 2 flushes partial sum, err sticky
    taps[0] = 640;
    taps[1] = 640;
    send(2, 1, 20);
    repeat (2) @(posedge clk);
    #1;
    chk("t33_err", err, 1);
    set4(3200, 0, 0, 0);
    send(4, 3, 50);
    repeat (2) @(posedge clk);
    #1;
    chk("t33_err_sticky", err, 1);

    // reset mid-sample with an undelivered output pending
    m_ready = 1'b0;
    set4(640, 640, 640, 640);
    send(4, 3, 40);
    send(2, -1, -1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_push -= sb.size();
    sb.delete();
    tb_tap = 0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t34_m_valid", m_valid, 0);
    chk("t34_err", err, 0);
    chk("t34_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    set4(-200, 5800, 1000, -200);
    send(4, 3, 100);
    repeat (2) @(posedge clk);
    #1;
    chk("t34_err_after", err, 0);

    // missing s_last at final tap still emits, flags err
    set4(6400, 0, 0, 0);
    send(4, -1, 100);
    repeat (2) @(posedge clk);
    #1;
    chk("miss_last_err", err, 1);

    // random products under random back-pressure
    bp_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 4; j++)
        taps[j] = int'($urandom_range(0, 8000)) - 2000;
      send(4, 3, -1);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1 m_ready = 1'b1;
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
    chk("out_count", n_out, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
